// File: rtl/sram_arb_2x1_if.sv
// SRAM-like request/response bundle shared by the two masters and the slave side of sram_arb_2x1.
// The master modport is the requester's view, and the slave modport is the responder's view.
interface sram_arb_2x1_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              req;
   logic              wr;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              addr_ok;
   logic              data_ok;

   modport master (
      output req, wr, size, addr, wdata,
      input  rdata, addr_ok, data_ok
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output rdata, addr_ok, data_ok
   );
endinterface

// File: rtl/sram_arb_2x1.sv
// Two-master to one-slave SRAM-like arbiter with zero-cycle request forwarding and one outstanding transaction.
// Defining ARB_ROUND_ROBIN_EN selects round-robin arbitration; by default, m1 has fixed priority over m0.
module sram_arb_2x1 (
   input logic           clk,
   input logic           rst,
   sram_arb_2x1_if.slave  m0,
   sram_arb_2x1_if.slave  m1,
   sram_arb_2x1_if.master s
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   owner;
   logic   owner_nxt;
   logic   win_vld;
   logic   winner;
   logic   own_req;
   logic   grant;
   logic   sel;
   logic   data_ph;

`ifdef ARB_ROUND_ROBIN_EN
   logic   ptr;
   logic   ptr_nxt;
`endif

   assign own_req = owner ? m1.req : m0.req;

   // Arbitration among live requests; only consulted in IDLE
   always_comb begin
      win_vld = m0.req | m1.req;
`ifdef ARB_ROUND_ROBIN_EN
      if (m0.req && m1.req) begin
         winner = ~ptr;
      end else begin
         winner = m1.req;
      end
`else
      winner = m1.req;
`endif
   end

   // State, owner and (optionally) last-served pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= 1'b0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= 1'b1;
      end else begin
         ptr <= ptr_nxt;
      end
   end
`endif

   // Next-state logic; slave handshakes only count while they are meaningful
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_nxt   = ptr;
`endif
      case (state)
         IDLE: begin
            if (win_vld) begin
               owner_nxt = winner;
               if (s.addr_ok) begin
                  state_nxt = DATA;
`ifdef ARB_ROUND_ROBIN_EN
                  ptr_nxt   = winner;
`endif
               end else begin
                  state_nxt = ADDR;
               end
            end
         end
         ADDR: begin
            if (!own_req) begin
               state_nxt = IDLE;
            end else if (s.addr_ok) begin
               state_nxt = DATA;
`ifdef ARB_ROUND_ROBIN_EN
               ptr_nxt   = owner;
`endif
            end
         end
         DATA: begin
            if (s.data_ok) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output steering: request mux toward the slave, response demux toward the owner
   always_comb begin
      grant      = 1'b0;
      sel        = 1'b0;
      data_ph    = 1'b0;
      s.req      = 1'b0;
      s.wr       = 1'b0;
      s.size     = '0;
      s.addr     = '0;
      s.wdata    = '0;
      m0.addr_ok = 1'b0;
      m0.data_ok = 1'b0;
      m0.rdata   = '0;
      m1.addr_ok = 1'b0;
      m1.data_ok = 1'b0;
      m1.rdata   = '0;

      if (!rst) begin
         case (state)
            IDLE: begin
               grant = win_vld;
               sel   = winner;
            end
            ADDR: begin
               grant = own_req;
               sel   = owner;
            end
            DATA: begin
               data_ph = 1'b1;
               sel     = owner;
            end
            default: begin
               grant = 1'b0;
            end
         endcase
      end

      if (grant) begin
         s.req = 1'b1;
         if (sel) begin
            s.wr       = m1.wr;
            s.size     = m1.size;
            s.addr     = m1.addr;
            s.wdata    = m1.wdata;
            m1.addr_ok = s.addr_ok;
         end else begin
            s.wr       = m0.wr;
            s.size     = m0.size;
            s.addr     = m0.addr;
            s.wdata    = m0.wdata;
            m0.addr_ok = s.addr_ok;
         end
      end

      if (data_ph) begin
         if (sel) begin
            m1.data_ok = s.data_ok;
            m1.rdata   = s.rdata;
         end else begin
            m0.data_ok = s.data_ok;
            m0.rdata   = s.rdata;
         end
      end
   end

endmodule
